// File: rtl/delay_var_bus.sv
// delay_var_bus: runtime-programmable bus delay line built on a circular buffer.
// The line advances one step per clk edge with ce=1 and behaves like a chain of
// N registers, where N = cur_delay is loaded (clamped to [1, MAX_DELAY]) by cfg_load.
// Every cfg_load flushes the line; q_valid marks samples that have traversed N steps.
// Optional build macro DELAY_VAR_ZEROFILL_EN: when defined, q is forced to 0
// while q_valid is low, so stale buffer contents never reach the output.
module delay_var_bus #(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 16,
  localparam int DW       = $clog2(MAX_DELAY) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic [DW-1:0]    cfg_delay,
  input  logic             cfg_load,
  output logic [DW-1:0]    cur_delay
);

  localparam int AW = $clog2(MAX_DELAY);

  logic [WIDTH-1:0] mem [MAX_DELAY];
  logic [AW-1:0]    wp;
  logic [DW-1:0]    fill;

  logic [DW-1:0]    n_load;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    fill_inc;
  logic             valid_step;
  logic [WIDTH-1:0] q_raw;

  // Saturate a requested delay into the legal range [1, MAX_DELAY].
  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] req);
    logic [DW-1:0] res;
    if (req == '0)
      res = DW'(1);
    else if (req > DW'(MAX_DELAY))
      res = DW'(MAX_DELAY);
    else
      res = req;
    return res;
  endfunction

  // Read address, fill advance and the sample that would emerge on this step.
  // rd_addr = wp - (N-1) in AW bits; N=MAX_DELAY wraps to wp+1 naturally.
  // N=1 reads the slot being written this cycle, so d is bypassed directly.
  always_comb begin
    n_load     = clamp_delay(cfg_delay);
    rd_addr    = wp - cur_delay[AW-1:0] + AW'(1);
    fill_inc   = (fill < cur_delay) ? fill + DW'(1) : fill;
    valid_step = (fill_inc == cur_delay);
    q_raw      = (cur_delay == DW'(1)) ? d : mem[rd_addr];
  end

  // Sample storage: written on every enabled step, deliberately not reset.
  always_ff @(posedge clk) begin
    if (ce)
      mem[wp] <= d;
  end

  // Control and output register: reconfiguration takes precedence over stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      fill      <= '0;
      cur_delay <= DW'(1);
      q_valid   <= 1'b0;
      q         <= '0;
    end else if (cfg_load) begin
      cur_delay <= n_load;
      q_valid   <= 1'b0;
      if (ce) begin
        wp   <= wp + AW'(1);
        fill <= DW'(1);
      end else begin
        fill <= '0;
      end
`ifdef DELAY_VAR_ZEROFILL_EN
      q <= '0;
`endif
    end else if (ce) begin
      wp      <= wp + AW'(1);
      fill    <= fill_inc;
      q_valid <= valid_step;
`ifdef DELAY_VAR_ZEROFILL_EN
      q <= q_raw & {WIDTH{valid_step}};
`else
      q <= q_raw;
`endif
    end
  end

endmodule
